csd2bin_arb: RTL and testbench

- Shares one combinational csd2bin converter among N requesters in the BKM FPU datapath.
- Arbitration is round-robin.
- Registers each operand before conversion and holds the result with requester tag until the consumer accepts it.
- Gives the FPU stages one CSD-to-binary resource with valid/ready handshakes on both sides.

---
 rtl/csd_pkg.sv | 42 ++++
 rtl/csd2bin.sv | 26 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/csd2bin_arb.sv | 124 ++++++++++++
 tb/tb_csd2bin_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csd_pkg.sv
// Shared definitions for the CSD-to-binary arbiter: word widths, FSM
// encoding, a constant clog2 helper and a behavioural CSD reference.
//
// CSD digit i sits in operand bits [2*i+1 : 2*i]:
//    2'b00 -> 0, 2'b01 -> +1, 2'b10 -> -1, 2'b11 -> 0 (the two halves cancel).
package csd_pkg;

   localparam int W    = 15;
   localparam int WCSD = 2 * W;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CONV = 2'd1;
   localparam logic [1:0] OUT  = 2'd2;

   // Bits needed to index 'value' items (never less than 1).
   function automatic int clog2(input int value);
      int bits;
      int rem;
      bits = 0;
      rem  = value - 1;
      while (rem > 0) begin
         bits++;
         rem = rem >>> 1;
      end
      return (bits == 0) ? 1 : bits;
   endfunction

   // Digit-by-digit signed sum of the CSD word, reduced modulo 2^W.
   function automatic logic [W-1:0] csd_ref(input logic [WCSD-1:0] csd);
      longint sum;
      sum = 0;
      for (int i = 0; i < W; i++) begin
         case (csd[2*i +: 2])
            2'b01:   sum = sum + (longint'(1) << i);
            2'b10:   sum = sum - (longint'(1) << i);
            default: sum = sum;
         endcase
      end
      return sum[W-1:0];
   endfunction

endpackage

// File: rtl/csd2bin.sv
// Combinational CSD-to-binary converter: the positive-digit bits and the
// negative-digit bits form two plain binary words whose difference is the
// value (digit 2'b11 adds and subtracts the same weight, i.e. zero).
module csd2bin #(
   parameter int W = 15
) (
   input  logic [2*W-1:0] x,
   output logic [W-1:0]   y
);

   logic [W-1:0] pos;
   logic [W-1:0] neg;

   // Split the interleaved digit pairs into positive and negative weights.
   always_comb begin
      pos = '0;
      neg = '0;
      for (int i = 0; i < W; i++) begin
         pos[i] = x[2*i];
         neg[i] = x[2*i+1];
      end
   end

   assign y = pos - neg;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin rotate-priority encoder: grants the first requester above
// 'ptr' (the previous winner), wrapping modulo N. Purely combinational.
module rr_arbiter
   import csd_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   input  logic           en,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id
);

   logic found;
   int   idx;

   // Walk ptr+1 .. ptr+N (mod N) and keep the first active requester.
   always_comb begin
      // NOTE: every output gets a default before the search so no path
      // leaves it unassigned, which would otherwise infer a latch.
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[IDW'(idx)]) begin
            found  = 1'b1;
            gnt_id = IDW'(idx);
         end
      end
      if (en && found) begin
         gnt[gnt_id] = 1'b1;
      end
   end

endmodule

// File: rtl/csd2bin_arb.sv
// Shares one csd2bin converter among N requesters. A round-robin grant
// registers the winning operand, the next cycle converts it, and the
// result is held with its requester tag until the consumer takes it.
module csd2bin_arb #(
   parameter int W    = csd_pkg::W,
   parameter int N    = 4,
   parameter int IDW  = csd_pkg::clog2(N),
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic [N-1:0]      req_valid,
   input  logic [N*2*W-1:0]  req_x,
   output logic [N-1:0]      req_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_y,
   output logic [IDW-1:0]    out_id,
   output logic              busy,
   output logic [CNTW-1:0]   done_cnt
);

   import csd_pkg::*;

   localparam int OPW = 2 * W;

   logic [1:0]     state;
   logic [OPW-1:0] x_reg;
   logic [IDW-1:0] id_reg;
   logic [IDW-1:0] ptr;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           free;
   logic           arb_en;
   logic           acc;
   logic [OPW-1:0] x_sel;
   logic [W-1:0]   conv_y;

   // A new operand can enter when idle, or when the held result leaves
   // this cycle; reset and ena=0 both suppress any grant.
   always_comb begin
      free   = (state == IDLE) || ((state == OUT) && out_ready);
      arb_en = rst_n && ena && free;
      acc    = arb_en && (|req_valid);
      x_sel  = req_x[int'(gnt_id)*OPW +: OPW];
   end

   rr_arbiter #(
      .N   (N),
      .IDW (IDW)
   ) u_arb (
      .req    (req_valid),
      .ptr    (ptr),
      .en     (arb_en),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign req_ready = gnt;
   assign busy      = (state != IDLE);

   csd2bin #(
      .W (W)
   ) u_conv (
      .x (x_reg),
      .y (conv_y)
   );

   // Capture the granted operand, its tag, and move the priority pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the operand register is reset as well, so a freshly reset
         // block never presents leftover data to the converter.
         x_reg  <= '0;
         id_reg <= '0;
         ptr    <= IDW'(N - 1);
      end else if (acc) begin
         // NOTE: non-blocking assignments so every register here samples
         // the values from before the edge, independent of statement order.
         x_reg  <= x_sel;
         id_reg <= gnt_id;
         ptr    <= gnt_id;
      end
   end

   // Control FSM: IDLE -> CONV -> OUT, back to CONV when a request is
   // accepted in the same cycle as the result handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_y     <= '0;
         out_id    <= '0;
         done_cnt  <= '0;
      end else if (ena) begin
         case (state)
            IDLE: begin
               if (acc) begin
                  state <= CONV;
               end
            end
            CONV: begin
               out_y     <= conv_y;
               out_id    <= id_reg;
               out_valid <= 1'b1;
               state     <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  done_cnt  <= done_cnt + CNTW'(1);
                  out_valid <= 1'b0;
                  state     <= acc ? CONV : IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_csd2bin_arb.sv
// Self-checking bench for csd2bin_arb: table of single-request vectors,
// directed reset / round-robin / backpressure / enable sequences, then a
// randomized sweep scored against a transaction-level model.
module tb_csd2bin_arb;

   import csd_pkg::*;

   localparam int N           = 4;
   localparam int IDW         = clog2(N);
   localparam int CNTW        = 16;
   localparam int RESULTS     = 10000;
   localparam int CYCLE_LIMIT = 60000;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              ena;
   logic [N-1:0]      req_valid;
   logic [N*WCSD-1:0] req_x;
   logic [N-1:0]      req_ready;
   logic              out_valid;
   logic              out_ready;
   logic [W-1:0]      out_y;
   logic [IDW-1:0]    out_id;
   logic              busy;
   logic [CNTW-1:0]   done_cnt;

   csd2bin_arb #(
      .W    (W),
      .N    (N),
      .IDW  (IDW),
      .CNTW (CNTW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_id    (out_id),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              id;
      logic [WCSD-1:0] csd;
      logic [W-1:0]    y;
   } vec_t;

   typedef struct {
      int           id;
      logic [W-1:0] y;
      int           rdy;
   } pend_t;

   int              vectors     = 0;
   int              miscompares = 0;
   int              exp_cnt;
   logic [WCSD-1:0] cur_x [N];
   pend_t           sb [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic drive_x();
      for (int i = 0; i < N; i++) begin
         req_x[i*WCSD +: WCSD] = cur_x[i];
      end
   endtask

   function automatic logic [WCSD-1:0] rand_csd();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[WCSD-1:0];
   endfunction

   // Spec-level round-robin choice: first valid requester after 'last'.
   function automatic int rr_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   initial begin
      vec_t         tbl [9];
      logic [W-1:0] ey;
      int           g;
      int           cyc;
      int           hs;
      int           last;
      int           max_wait;
      int           wait_cnt [N];
      logic         model_ov;
      logic         hs_now;
      logic [N-1:0] exp_gnt;
      pend_t        p;

      tbl[0] = '{id: 2, csd: 30'h0000_0000, y: 15'h0000};
      tbl[1] = '{id: 0, csd: 30'h0000_0001, y: 15'h0001};
      tbl[2] = '{id: 1, csd: 30'h0000_0008, y: 15'h7FFE};
      tbl[3] = '{id: 3, csd: 30'h1000_0000, y: 15'h4000};
      tbl[4] = '{id: 0, csd: 30'h2000_0000, y: 15'h4000};
      tbl[5] = '{id: 1, csd: 30'h0000_0042, y: 15'h0007};
      tbl[6] = '{id: 2, csd: 30'h3FFF_FFFF, y: 15'h0000};
      tbl[7] = '{id: 3, csd: 30'h1555_5555, y: 15'h7FFF};
      tbl[8] = '{id: 0, csd: 30'h2AAA_AAAA, y: 15'h0001};

      // ---------------- reset state ----------------
      rst_n     = 1'b0;
      ena       = 1'b1;
      out_ready = 1'b0;
      req_valid = 4'b0001;
      for (int i = 0; i < N; i++) cur_x[i] = '0;
      drive_x();
      tick();
      tick();
      mid();
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done_cnt", done_cnt, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_id", out_id, 0);
      check("rst_req_ready", req_ready, 0);
      tick();
      rst_n     = 1'b1;
      req_valid = '0;
      exp_cnt   = 0;

      // ---------------- single-request table ----------------
      foreach (tbl[i]) begin
         req_valid          = N'(1) << tbl[i].id;
         cur_x[tbl[i].id]   = tbl[i].csd;
         drive_x();
         out_ready          = 1'b1;
         mid();
         check("tbl_grant", req_ready, N'(1) << tbl[i].id);
         tick();
         req_valid = '0;
         mid();
         check("tbl_conv_busy", busy, 1);
         check("tbl_conv_valid", out_valid, 0);
         tick();
         mid();
         check("tbl_valid", out_valid, 1);
         check("tbl_y", out_y, tbl[i].y);
         check("tbl_id", out_id, tbl[i].id);
         tick();
         exp_cnt++;
         mid();
         check("tbl_idle_valid", out_valid, 0);
         check("tbl_idle_busy", busy, 0);
         check("tbl_cnt", done_cnt, exp_cnt);
         tick();
      end

      // ---------------- reset in the middle of CONV ----------------
      req_valid = 4'b0001;
      cur_x[0]  = rand_csd();
      drive_x();
      mid();
      check("prerst_grant", req_ready, 4'b0001);
      tick();
      #1;
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", out_valid, 0);
      check("midrst_cnt", done_cnt, 0);
      check("midrst_ready", req_ready, 0);
      exp_cnt = 0;
      for (int i = 0; i < N; i++) cur_x[i] = rand_csd();
      drive_x();
      tick();
      rst_n = 1'b1;

      // ---------------- round-robin, all requesters active ----------------
      mid();
      for (int i = 0; i < 5; i++) begin
         g = i % N;
         check("rr_grant", req_ready, N'(1) << g);
         ey = csd_ref(cur_x[g]);
         tick();
         cur_x[g] = rand_csd();
         drive_x();
         mid();
         check("rr_conv_ready", req_ready, 0);
         check("rr_conv_valid", out_valid, 0);
         check("rr_cnt", done_cnt, exp_cnt);
         tick();
         mid();
         check("rr_valid", out_valid, 1);
         check("rr_id", out_id, g);
         check("rr_y", out_y, ey);
         exp_cnt++;
      end

      // ---------------- result backpressure ----------------
      out_ready = 1'b0;
      #1;
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", out_valid, 1);
         check("bp_id", out_id, 0);
         check("bp_y", out_y, ey);
         check("bp_ready", req_ready, 0);
         check("bp_cnt", done_cnt, exp_cnt - 1);
         mid();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_grant", req_ready, 4'b0010);
      ey = csd_ref(cur_x[1]);
      tick();
      cur_x[1] = rand_csd();
      drive_x();
      mid();
      check("bp_release_cnt", done_cnt, exp_cnt);
      check("bp_release_busy", busy, 1);
      check("bp_release_valid", out_valid, 0);

      // ---------------- enable freeze during CONV ----------------
      ena = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         mid();
         check("frz_busy", busy, 1);
         check("frz_valid", out_valid, 0);
         check("frz_ready", req_ready, 0);
         check("frz_cnt", done_cnt, exp_cnt);
      end
      ena = 1'b1;
      tick();
      mid();
      check("frz_done_valid", out_valid, 1);
      check("frz_done_id", out_id, 1);
      check("frz_done_y", out_y, ey);

      // ena low in OUT: out_ready ignored, no grant, no count
      ena = 1'b0;
      #1;
      check("ena_out_ready", req_ready, 0);
      tick();
      mid();
      check("ena_out_valid", out_valid, 1);
      check("ena_out_cnt", done_cnt, exp_cnt);
      ena = 1'b1;
      #1;
      check("ena_back_grant", req_ready, 4'b0100);
      exp_cnt++;
      tick();
      mid();
      check("ena_back_cnt", done_cnt, exp_cnt);

      // ---------------- randomized sweep ----------------
      rst_n     = 1'b0;
      req_valid = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) begin
         cur_x[i]     = rand_csd();
         req_valid[i] = ($urandom_range(0, 3) != 0);
         wait_cnt[i]  = 0;
      end
      drive_x();
      out_ready = ($urandom_range(0, 3) != 0);
      sb.delete();
      exp_cnt  = 0;
      last     = N - 1;
      cyc      = 0;
      hs       = 0;
      max_wait = 0;

      while (hs < RESULTS && cyc < CYCLE_LIMIT) begin
         @(negedge clk);
         cyc++;
         model_ov = (sb.size() > 0) && (cyc >= sb[0].rdy);
         hs_now   = model_ov && out_ready;
         check("swp_busy", busy, sb.size() > 0);
         check("swp_valid", out_valid, model_ov);

         exp_gnt = '0;
         g       = -1;
         if ((|req_valid) && (sb.size() == 0 || hs_now)) begin
            g       = rr_pick(req_valid, last);
            exp_gnt = N'(1) << g;
         end
         check("swp_grant", req_ready, exp_gnt);

         if (hs_now) begin
            p = sb.pop_front();
            check("swp_y", out_y, p.y);
            check("swp_id", out_id, p.id);
            exp_cnt++;
            hs++;
         end

         if (g >= 0) begin
            sb.push_back('{id: g, y: csd_ref(cur_x[g]), rdy: cyc + 2});
            for (int j = 0; j < N; j++) begin
               if (j != g && req_valid[j]) begin
                  wait_cnt[j]++;
                  if (wait_cnt[j] > max_wait) max_wait = wait_cnt[j];
               end
            end
            wait_cnt[g] = 0;
            last        = g;
         end

         @(posedge clk);
         #1;
         check("swp_cnt", done_cnt, exp_cnt[CNTW-1:0]);

         if (g >= 0) begin
            cur_x[g]     = rand_csd();
            req_valid[g] = ($urandom_range(0, 3) != 0);
         end
         for (int j = 0; j < N; j++) begin
            if (!req_valid[j]) req_valid[j] = ($urandom_range(0, 1) != 0);
         end
         drive_x();
         out_ready = ($urandom_range(0, 3) != 0);
      end

      check("swp_results", hs, RESULTS);
      check("swp_starvation", max_wait <= N - 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
